ldpc_qc_encoder: RTL and testbench

Systematic QC-LDPC encoder for the same base matrix format that ldpc_core decodes: C x R base matrix, lifting factor D, dual-diagonal parity part. It accepts (R-C)*D information bits and returns an R*D-bit codeword that satisfies H*cw = 0. It is the transmit end of the link-test path and feeds the modulator/noise/quant chain in place of the implicit all-zero codeword.

---
 rtl/ldpc_pkg.sv | 24 ++
 rtl/ldpc_qc_encoder_rotate.sv | 27 ++
 rtl/ldpc_qc_encoder.sv | 191 +++++++++++++++++++
 tb/tb_ldpc_qc_encoder.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_pkg.sv
// Shared definitions for the QC-LDPC encoder/decoder pair: default geometry,
// base-matrix entry addressing and the encoder FSM state set.
package ldpc_pkg;

  localparam int LDPC_R     = 24;
  localparam int LDPC_C     = 12;
  localparam int LDPC_D     = 96;
  localparam int LDPC_MTX_W = 8;
  localparam int NULL_SHIFT = -1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAMBDA,
    ST_P0,
    ST_PAR,
    ST_OUT
  } state_t;

  // Bit offset of base-matrix entry (r,c) inside the flat mtx bus.
  function automatic int entry_off(input int r, input int c, input int ncols, input int w);
    return (r * ncols + c) * w;
  endfunction

endpackage

// File: rtl/ldpc_qc_encoder_rotate.sv
// D-bit cyclic rotator: vout[k] = vin[(k+shift) mod D], or zero when en is low
// (null circulant block).
module qc_rotate #(
  parameter int D  = 96,
  parameter int SW = $clog2(D)
) (
  input  logic [D-1:0]  vin,
  input  logic [SW-1:0] shift,
  input  logic          en,
  output logic [D-1:0]  vout
);

  logic [SW:0] idx;

  always_comb begin
    vout = '0;
    idx  = '0;
    if (en) begin
      for (int k = 0; k < D; k++) begin
        idx = (SW+1)'(k) + {1'b0, shift};
        if (idx >= (SW+1)'(D)) idx = idx - (SW+1)'(D);
        vout[k] = vin[idx[SW-1:0]];
      end
    end
  end

endmodule

// File: rtl/ldpc_qc_encoder.sv
// Systematic QC-LDPC encoder for dual-diagonal base matrices: per-row lambda
// accumulation, one-step p0 solve, then back-substitution down the diagonal.
module ldpc_qc_encoder
  import ldpc_pkg::*;
#(
  parameter int R     = LDPC_R,
  parameter int C     = LDPC_C,
  parameter int D     = LDPC_D,
  parameter int mtx_w = LDPC_MTX_W
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [C*R*mtx_w-1:0] mtx,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [(R-C)*D-1:0]   info,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [R*D-1:0]       cw,
  output logic                 cfg_err,
  output logic [2:0]           dbg_state
);

  localparam int K  = (R - C) * D;
  localparam int N  = R * D;
  localparam int I  = R - C;
  localparam int SW = $clog2(D);
  localparam int RW = $clog2(C);
  localparam logic [RW-1:0] ROW_LAST = RW'(C - 1);
  localparam logic [RW-1:0] PAR_LAST = RW'(C - 2);

  // Handshake: a word moves on any rising edge where valid and ready are both
  // high; in_ready is high only in IDLE, out_valid only in OUT, and neither
  // side may retract its data while waiting.

  state_t         state;
  logic [RW-1:0]  r_q;
  logic [K-1:0]   info_q;
  logic [D-1:0]   lambda_q [C];
  logic [D-1:0]   par_q    [C];
  logic [D-1:0]   acc_q;

  function automatic logic [mtx_w-1:0] ent(input logic [C*R*mtx_w-1:0] m, input int r, input int c);
    return m[entry_off(r, c, R, mtx_w) +: mtx_w];
  endfunction

  function automatic logic ent_ok(input logic [mtx_w-1:0] e);
    int v;
    v = int'($signed(e));
    return (v > NULL_SHIFT) && (v < D);
  endfunction

  function automatic logic ent_bad(input logic [mtx_w-1:0] e);
    return int'($signed(e)) >= D;
  endfunction

  function automatic logic [SW-1:0] ent_shift(input logic [mtx_w-1:0] e);
    return SW'(e);
  endfunction

  logic [D-1:0]  rot_info [I];
  logic [SW-1:0] sh_info  [I];
  logic          en_info  [I];
  logic [D-1:0]  lam;
  logic          row_err;
  logic [SW-1:0] z_sh;
  logic [D-1:0]  p_in, rot_p, p_new;
  logic [SW-1:0] p_sh;
  logic          p_en;
  logic [N-1:0]  cw_next;

  always_comb begin
    for (int j = 0; j < I; j++) begin
      sh_info[j] = ent_shift(ent(mtx, int'(r_q), j));
      en_info[j] = ent_ok(ent(mtx, int'(r_q), j));
    end
  end

  for (genvar j = 0; j < I; j++) begin : g_rot
    qc_rotate #(.D(D)) u_rot (
      .vin   (info_q[j*D +: D]),
      .shift (sh_info[j]),
      .en    (en_info[j]),
      .vout  (rot_info[j])
    );
  end

  always_comb begin
    lam     = '0;
    row_err = 1'b0;
    for (int j = 0; j < I; j++) lam = lam ^ rot_info[j];
    for (int c = 0; c < R; c++) row_err = row_err | ent_bad(ent(mtx, int'(r_q), c));
  end

  // z is the shift of the single interior non-null entry in the p0 column.
  always_comb begin
    z_sh = '0;
    for (int r = 1; r < C - 1; r++)
      if (ent_ok(ent(mtx, r, I))) z_sh = ent_shift(ent(mtx, r, I));
  end

  always_comb begin
    if (state == ST_P0) begin
      p_in = acc_q;
      p_sh = (z_sh == '0) ? '0 : SW'(D - int'(z_sh));
      p_en = 1'b1;
    end else begin
      p_in = par_q[0];
      p_sh = ent_shift(ent(mtx, int'(r_q), I));
      p_en = ent_ok(ent(mtx, int'(r_q), I));
    end
  end

  qc_rotate #(.D(D)) u_rot_p (
    .vin   (p_in),
    .shift (p_sh),
    .en    (p_en),
    .vout  (rot_p)
  );

  always_comb begin
    p_new = lambda_q[r_q] ^ rot_p;
    if (r_q != '0) p_new = p_new ^ par_q[r_q];
    cw_next = '0;
    cw_next[K-1:0] = info_q;
    for (int j = 0; j < C - 1; j++) cw_next[K + j*D +: D] = par_q[j];
    cw_next[K + (C-1)*D +: D] = p_new;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      cw        <= '0;
      cfg_err   <= 1'b0;
      r_q       <= '0;
      info_q    <= '0;
      acc_q     <= '0;
      for (int i = 0; i < C; i++) begin
        lambda_q[i] <= '0;
        par_q[i]    <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            info_q   <= info;
            r_q      <= '0;
            acc_q    <= '0;
            in_ready <= 1'b0;
            state    <= ST_LAMBDA;
          end
        end
        ST_LAMBDA: begin
          lambda_q[r_q] <= lam;
          acc_q         <= acc_q ^ lam;
          if (row_err) cfg_err <= 1'b1;
          if (r_q == ROW_LAST) state <= ST_P0;
          else r_q <= r_q + RW'(1);
        end
        ST_P0: begin
          par_q[0] <= rot_p;
          r_q      <= '0;
          state    <= ST_PAR;
        end
        ST_PAR: begin
          par_q[r_q + RW'(1)] <= p_new;
          if (r_q == PAR_LAST) begin
            cw        <= cw_next;
            out_valid <= 1'b1;
            state     <= ST_OUT;
          end else begin
            r_q <= r_q + RW'(1);
          end
        end
        ST_OUT: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_ldpc_qc_encoder.sv
// Self-checking bench for ldpc_qc_encoder: codewords are judged by their
// systematic part and by the full H*cw syndrome computed from the base matrix.
module tb_ldpc_qc_encoder;
  import ldpc_pkg::*;

  localparam int R = 24;
  localparam int C = 12;
  localparam int D = 96;
  localparam int K = (R - C) * D;
  localparam int N = R * D;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rstn;
  logic [C*R*8-1:0] mtx;
  logic             in_valid;
  logic             in_ready;
  logic [K-1:0]     info;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     cw;
  logic             cfg_err;
  logic [2:0]       dbg_state;

  always #5 clk = ~clk;

  ldpc_qc_encoder dut (
    .clk       (clk),
    .rstn      (rstn),
    .mtx       (mtx),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .info      (info),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cw        (cw),
    .cfg_err   (cfg_err),
    .dbg_state (dbg_state)
  );

  int errors;
  int checks;
  logic [K-1:0] exp_q[$];

  // Rate-1/2 base matrix, z=96 (x=7 at rows 0/11, z-shift 0 at row 5).
  int base [C][R] = '{
    '{-1,94,73,-1,-1,-1,-1,-1,55,83,-1,-1,  7, 0,-1,-1,-1,-1,-1,-1,-1,-1,-1,-1},
    '{-1,27,-1,-1,-1,22,79, 9,-1,-1,-1,12, -1, 0, 0,-1,-1,-1,-1,-1,-1,-1,-1,-1},
    '{-1,-1,-1,24,22,81,-1,33,-1,-1,-1, 0, -1,-1, 0, 0,-1,-1,-1,-1,-1,-1,-1,-1},
    '{61,-1,47,-1,-1,-1,-1,-1,65,25,-1,-1, -1,-1,-1, 0, 0,-1,-1,-1,-1,-1,-1,-1},
    '{-1,-1,39,-1,-1,-1,84,-1,-1,41,72,-1, -1,-1,-1,-1, 0, 0,-1,-1,-1,-1,-1,-1},
    '{-1,-1,-1,-1,46,40,-1,82,-1,-1,-1,79,  0,-1,-1,-1,-1, 0, 0,-1,-1,-1,-1,-1},
    '{-1,-1,95,53,-1,-1,-1,-1,-1,14,18,-1, -1,-1,-1,-1,-1,-1, 0, 0,-1,-1,-1,-1},
    '{-1,11,73,-1,-1,-1, 2,-1,-1,47,-1,-1, -1,-1,-1,-1,-1,-1,-1, 0, 0,-1,-1,-1},
    '{12,-1,-1,-1,83,24,-1,43,-1,-1,-1,51, -1,-1,-1,-1,-1,-1,-1,-1, 0, 0,-1,-1},
    '{-1,-1,-1,-1,-1,94,-1,59,-1,-1,70,72, -1,-1,-1,-1,-1,-1,-1,-1,-1, 0, 0,-1},
    '{-1,-1, 7,65,-1,-1,-1,-1,39,49,-1,-1, -1,-1,-1,-1,-1,-1,-1,-1,-1,-1, 0, 0},
    '{43,-1,-1,-1,-1,66,-1,41,-1,-1,-1,26,  7,-1,-1,-1,-1,-1,-1,-1,-1,-1,-1, 0}
  };
  int mat [C][R];

  // ---------------- reference model ----------------
  function automatic logic [D-1:0] rot(input logic [D-1:0] v, input int s);
    if (s == 0) return v;
    return (v >> s) | (v << (D - s));
  endfunction

  // OR of all block-row syndromes; entries outside 0..D-1 count as null.
  function automatic logic [D-1:0] syn_or(input logic [N-1:0] w);
    logic [D-1:0] s, all;
    all = '0;
    for (int r = 0; r < C; r++) begin
      s = '0;
      for (int c = 0; c < R; c++)
        if (mat[r][c] >= 0 && mat[r][c] < D) s = s ^ rot(w[c*D +: D], mat[r][c]);
      all = all | s;
    end
    return all;
  endfunction

  function automatic logic [K-1:0] rand_word();
    logic [K-1:0] v;
    for (int i = 0; i < K / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wide(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    int b;
    checks++;
    assert (obs === exp) else begin
      errors++;
      b = 0;
      for (int i = R - 1; i >= 0; i--) if (obs[i*D +: D] !== exp[i*D +: D]) b = i;
      $error("FAIL %s: block %0d observed %h expected %h", tag, b, obs[b*D +: D], exp[b*D +: D]);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic pack_mtx();
    for (int r = 0; r < C; r++)
      for (int c = 0; c < R; c++) mtx[(r*R + c)*8 +: 8] = 8'(mat[r][c]);
  endtask

  task automatic start_word(input logic [K-1:0] w);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_wait", in_ready, 1);
    info     = w;
    in_valid = 1'b1;
    exp_q.push_back(w);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat, output bit rdy_seen);
    lat = 0;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_out(input string tag, input int lat, input bit rdy_seen, input logic exp_err);
    logic [K-1:0] exp;
    exp = '0;
    chk({tag, "_latency"}, lat, 2 * C);
    chk({tag, "_busy"}, rdy_seen, 0);
    chk({tag, "_sb_nonempty"}, exp_q.size() > 0, 1);
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    chk_wide({tag, "_info"}, N'(cw[K-1:0]), N'(exp));
    chk({tag, "_syndrome"}, syn_or(cw), 0);
    chk({tag, "_cfg_err"}, cfg_err, exp_err);
  endtask

  task automatic encode(input string tag, input logic [K-1:0] w, input logic exp_err);
    int lat;
    bit rdy_seen;
    start_word(w);
    wait_out(lat, rdy_seen);
    check_out(tag, lat, rdy_seen, exp_err);
    @(posedge clk); #1;
    chk({tag, "_valid_drop"}, out_valid, 0);
    chk({tag, "_ready_back"}, in_ready, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [K-1:0] w;
    logic [N-1:0] snap;
    int  lat;
    bit  rdy_seen, held, stable, ghost;

    errors = 0;
    checks = 0;
    rstn = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    info = '0;
    mat = base;
    pack_mtx();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk_wide("rst_cw", cw, '0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    rstn = 1'b1;
    @(posedge clk); #1;

    encode("zero", '0, 1'b0);
    chk_wide("zero_cw", cw, '0);

    w = '0;
    w[0] = 1'b1;
    encode("bit0", w, 1'b0);
    chk("bit0_cw0", cw[0], 1);

    for (int i = 0; i < 200; i++) encode("rand", rand_word(), 1'b0);

    // Non-zero interior shift exercises the p0 inverse rotation.
    mat[5][12] = 37;
    pack_mtx();
    for (int i = 0; i < 20; i++) encode("zvar", rand_word(), 1'b0);
    mat = base;
    pack_mtx();

    // Back-pressure: output held, stray in_valid pulses ignored.
    out_ready = 1'b0;
    start_word(rand_word());
    wait_out(lat, rdy_seen);
    check_out("bp", lat, rdy_seen, 1'b0);
    snap = cw;
    held = 1'b1;
    stable = 1'b1;
    ghost = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (i % 10 == 3) begin
        in_valid = 1'b1;
        info = rand_word();
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (!out_valid) held = 1'b0;
      if (cw !== snap) stable = 1'b0;
      if (in_ready) ghost = 1'b1;
    end
    chk("bp_valid_held", held, 1);
    chk("bp_cw_stable", stable, 1);
    chk("bp_in_ready_low", ghost, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_valid_drop", out_valid, 0);
    chk("bp_ready_back", in_ready, 1);
    ghost = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready) ghost = 1'b1;
    end
    chk("bp_no_ghost_word", ghost, 0);
    encode("bp_next", rand_word(), 1'b0);

    // Reset in the middle of an encode.
    start_word(rand_word());
    repeat (9) begin
      @(posedge clk); #1;
    end
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk_wide("midrst_cw", cw, '0);
    chk("midrst_state", dbg_state, ST_IDLE);
    rstn = 1'b1;
    exp_q.delete();
    ghost = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) ghost = 1'b1;
    end
    chk("midrst_no_output", ghost, 0);
    encode("post_rst", rand_word(), 1'b0);

    // Illegal entry: treated as null, cfg_err sticky until reset.
    mat[3][2] = 100;
    pack_mtx();
    encode("bad_entry", rand_word(), 1'b1);
    encode("bad_entry2", rand_word(), 1'b1);
    chk("bad_entry_hold", cfg_err, 1);
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("bad_entry_rst", cfg_err, 0);
    rstn = 1'b1;

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
